// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
//
// Parametrised SPI slave. SCK, CHIP_SELECT and MOSI are oversampled in the CLK
// domain: two synchroniser flops plus a third SCK flop for edge detection, so a
// pin edge takes effect 3 CLK after it occurs. Supports all four CPOL/CPHA
// modes, MSB- or LSB-first bit order, valid/ready word interfaces and sticky
// overrun/underrun flags.
//
// Optional feature macro: SPI_SLV_RX_FIFO_EN
//   defined   - FIFO_DEPTH-entry first-word-fall-through RX FIFO
//   undefined - single RX holding register
//
// Ports
//   CLK          system clock, at least 4x the SCK frequency
//   RESET_N      asynchronous active-low reset
//   SCK          SPI clock (asynchronous)
//   CHIP_SELECT  active-low slave select (asynchronous)
//   MOSI         serial data in
//   MISO         serial data out (registered)
//   MISO_OE      MISO output enable, high while select is active
//   rx_data      received word
//   rx_valid     rx_data valid
//   rx_ready     consumer accepts rx_data
//   tx_data      next word to transmit
//   tx_valid     tx_data valid
//   tx_ready     1-cycle pulse: tx_data captured
//   rx_overrun   sticky: received word dropped
//   tx_underrun  sticky: word sent without valid tx_data
//   err_clr      clears both sticky flags (a new error in the same cycle wins)
//   busy         select active with a partial word in progress
// -----------------------------------------------------------------------------
module spi_slave_param #(
    parameter int WIDTH      = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             SCK,
    input  logic             CHIP_SELECT,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    input  logic             err_clr,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 32 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("spi_slave_param: unsupported WIDTH or FIFO_DEPTH");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [2:0] sck_s;
    logic [1:0] cs_s;
    logic [1:0] mosi_s;

    // NOTE: synchronisers reset to the idle pin levels so that releasing reset
    // never looks like a select fall or an SCK edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_s  <= {3{CPOL}};
            cs_s   <= 2'b11;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            cs_s   <= {cs_s[0], CHIP_SELECT};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end

    logic sel, leading, trailing, sample_edge, launch_edge, cs_fall, cs_rise;

    assign sel         = ~cs_s[1];
    assign leading     = (sck_s[1] != CPOL) && (sck_s[2] == CPOL);
    assign trailing    = (sck_s[1] == CPOL) && (sck_s[2] != CPOL);
    assign sample_edge = (state == ACTIVE) && sel && (CPHA ? trailing : leading);
    assign launch_edge = (state == ACTIVE) && sel && (CPHA ? leading : trailing);
    assign cs_fall     = (state == IDLE) && sel;
    assign cs_rise     = (state == ACTIVE) && !sel;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel)  state_next = ACTIVE;
            ACTIVE:  if (!sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive shifter and bit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic             push;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            push     <= 1'b0;
        end else begin
            push <= 1'b0;
            if (cs_rise) begin
                // Partial word is abandoned.
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_edge) begin
                rx_shift <= MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_s[1]}
                                      : {mosi_s[1], rx_shift[WIDTH-1:1]};
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    bit_cnt <= '0;
                    push    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy    = (state == ACTIVE) && sel && (bit_cnt != '0);
    assign MISO_OE = sel;

    // ------------------------------------------------------------------
    // Transmit shifter
    // ------------------------------------------------------------------
    // With bit_cnt back at 0 a launch edge is a word boundary: for CPHA=0 it
    // follows the last sample, for CPHA=1 it opens the next word. The first
    // CPHA=1 launch after select fall is skipped since the word is already
    // loaded and its first bit already on MISO.
    logic [WIDTH-1:0] tx_shift, tx_next;
    logic             first_launch, load, shift;

    assign load  = cs_fall || (launch_edge && !first_launch && (bit_cnt == '0));
    assign shift = launch_edge && !first_launch && (bit_cnt != '0);

    always_comb begin
        tx_next = tx_shift;
        if (load)
            tx_next = tx_valid ? tx_data : '1;
        else if (shift)
            tx_next = MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b1}
                                : {1'b1, tx_shift[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_shift     <= '0;
            MISO         <= 1'b0;
            tx_ready     <= 1'b0;
            first_launch <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            tx_shift <= tx_next;
            tx_ready <= load && tx_valid;
            if (load || shift)
                MISO <= MSB_FIRST ? tx_next[WIDTH-1] : tx_next[0];
            if (cs_fall)          first_launch <= CPHA;
            else if (launch_edge) first_launch <= 1'b0;
            if (load && !tx_valid) tx_underrun <= 1'b1;
            else if (err_clr)      tx_underrun <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RX word buffering
    // ------------------------------------------------------------------
`ifdef SPI_SLV_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, pop, accept;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && rx_ready;
    // A pop in the same cycle frees the slot, so a push when full is taken.
    assign accept = push && (!full || pop);

    // NOTE: storage has no reset; the read mux below masks it while empty.
    always_ff @(posedge CLK) begin
        if (accept) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept) rx_overrun <= 1'b1;
            else if (err_clr)    rx_overrun <= 1'b0;
        end
    end

    assign rx_valid = !empty;
    assign rx_data  = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (push) begin
                // Empty, or being popped this cycle: take the new word.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (push && rx_valid && !rx_ready) rx_overrun <= 1'b1;
            else if (err_clr)                  rx_overrun <= 1'b0;
        end
    end
`endif

endmodule
